// File: rtl/cache_refill_ctrl.sv
// Direct-mapped cache refill controller: 16 lines, write-through with
// write-allocate, single outstanding memory transaction, hit/miss counters.
module cache_refill_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       inv,
    output logic       cache_we,
    output logic [7:0] cache_addr,
    output logic [7:0] cache_din,
    input  logic [7:0] cache_dout,
    input  logic       cache_hit,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [7:0] hit_cnt,
    output logic [7:0] miss_cnt
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned LINES  = 16;
    localparam int unsigned CNT_W  = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] MEM_RD = 3'd2;
    localparam logic [2:0] FILL   = 3'd3;
    localparam logic [2:0] MEM_WR = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]        state_q,     state_nxt;
    logic [LINES-1:0]  valid_q,     valid_nxt;
    logic              req_we_q,    req_we_nxt;
    logic [ADDR_W-1:0] req_addr_q,  req_addr_nxt;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_nxt;
    logic [DATA_W-1:0] fill_q,      fill_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [CNT_W-1:0]  hit_nxt,     miss_nxt;
    logic              cpu_ack_nxt, cache_we_nxt, mem_req_nxt, mem_we_nxt;
    logic [DATA_W-1:0] cache_din_nxt;
    logic [IDX_W-1:0]  idx;
    logic              read_hit;

    // Array and memory always see the latched request address
    assign cache_addr = req_addr_q;
    assign mem_addr   = req_addr_q;
    assign mem_wdata  = req_wdata_q;

    assign idx      = req_addr_q[IDX_W-1:0];
    assign read_hit = cache_hit & valid_q[idx];

    // State, request latches, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            fill_q      <= '0;
            cpu_rdata   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            cpu_ack     <= 1'b0;
            cache_we    <= 1'b0;
            cache_din   <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            valid_q     <= valid_nxt;
            req_we_q    <= req_we_nxt;
            req_addr_q  <= req_addr_nxt;
            req_wdata_q <= req_wdata_nxt;
            fill_q      <= fill_nxt;
            cpu_rdata   <= rdata_nxt;
            hit_cnt     <= hit_nxt;
            miss_cnt    <= miss_nxt;
            cpu_ack     <= cpu_ack_nxt;
            cache_we    <= cache_we_nxt;
            cache_din   <= cache_din_nxt;
            mem_req     <= mem_req_nxt;
            mem_we      <= mem_we_nxt;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // are flops that line up exactly with the state they belong to
    always_comb begin
        state_nxt     = state_q;
        valid_nxt     = valid_q;
        req_we_nxt    = req_we_q;
        req_addr_nxt  = req_addr_q;
        req_wdata_nxt = req_wdata_q;
        fill_nxt      = fill_q;
        rdata_nxt     = cpu_rdata;
        hit_nxt       = hit_cnt;
        miss_nxt      = miss_cnt;

        case (state_q)
            IDLE: begin
                if (inv) begin
                    valid_nxt = '0;
                end else if (cpu_req) begin
                    req_we_nxt    = cpu_we;
                    req_addr_nxt  = cpu_addr;
                    req_wdata_nxt = cpu_wdata;
                    state_nxt     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_we_q) begin
                    valid_nxt[idx] = 1'b1;
                    state_nxt      = MEM_WR;
                end else if (read_hit) begin
                    rdata_nxt = cache_dout;
                    hit_nxt   = (hit_cnt == {CNT_W{1'b1}}) ? hit_cnt
                                                           : hit_cnt + CNT_W'(1);
                    state_nxt = RESP;
                end else begin
                    miss_nxt  = (miss_cnt == {CNT_W{1'b1}}) ? miss_cnt
                                                             : miss_cnt + CNT_W'(1);
                    state_nxt = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    fill_nxt  = mem_rdata;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                valid_nxt[idx] = 1'b1;
                rdata_nxt      = fill_q;
                state_nxt      = RESP;
            end
            MEM_WR: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        cpu_ack_nxt   = (state_nxt == RESP);
        cache_we_nxt  = (state_nxt == FILL) || ((state_nxt == LOOKUP) && req_we_nxt);
        cache_din_nxt = (state_nxt == FILL) ? fill_nxt : req_wdata_nxt;
        mem_req_nxt   = (state_nxt == MEM_RD) || (state_nxt == MEM_WR);
        mem_we_nxt    = (state_nxt == MEM_WR);
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl with a behavioural cache array and
// a configurable-latency memory model.
module tb_cache_refill_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cpu_req, cpu_we, inv;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       cache_we, cache_hit;
    logic [7:0] cache_addr, cache_din, cache_dout;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] hit_cnt, miss_cnt;

    cache_refill_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .inv(inv),
        .cache_we(cache_we), .cache_addr(cache_addr), .cache_din(cache_din),
        .cache_dout(cache_dout), .cache_hit(cache_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdata;
        int         lat;
        int         acc;
    } exp_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mem_exp_t;

    exp_t     exp_q[$];
    mem_exp_t mem_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int we_pulses = 0;
    int mem_wait_cfg = 0;
    logic [7:0] mem_data_cfg = 8'h00;

    // Cache array model: tags survive invalidate, only the DUT tracks valid
    logic [3:0] tag_a [16];
    logic [7:0] data_a [16];
    assign cache_hit  = (tag_a[cache_addr[3:0]] == cache_addr[7:4]);
    assign cache_dout = data_a[cache_addr[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cache_we) begin
            tag_a[cache_addr[3:0]]  <= cache_addr[7:4];
            data_a[cache_addr[3:0]] <= cache_din;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every cpu_ack
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (cache_we === 1'b1) we_pulses++;
                if (cpu_ack === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_cpu_ack", 32'(cpu_ack), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
                        chk("ack_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    resp_cnt++;
                end
            end
        end
    end

    // Memory model: acks after mem_wait_cfg wait cycles, checks each access
    initial begin
        int wcnt;
        mem_exp_t m;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req === 1'b1 && reset_n === 1'b1) begin
                if (wcnt == mem_wait_cfg) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data_cfg;
                    wcnt      = 0;
                    if (mem_q.size() == 0) begin
                        chk("unexpected_mem_req", 32'(mem_req), 32'd0);
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(m.we));
                        chk("mem_addr", 32'(mem_addr), 32'(m.addr));
                        if (m.we) chk("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // One CPU transaction; returns once the response has been seen
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                          input logic with_inv, input int n_wait, input logic [7:0] md,
                          input logic [7:0] exp_rd, input int exp_lat,
                          input logic exp_mem, input int exp_pulses);
        exp_t     e;
        mem_exp_t m;
        int       target;
        bit       done;
        @(negedge clk);
        mem_wait_cfg = n_wait;
        mem_data_cfg = md;
        if (exp_mem) begin
            m.we = we; m.addr = addr; m.wdata = wd;
            mem_q.push_back(m);
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; inv = with_inv;
        if (with_inv) begin
            @(posedge clk);
            @(negedge clk);
            inv = 1'b0;
        end
        @(posedge clk);
        #1;
        e.rdata = exp_rd; e.lat = exp_lat; e.acc = cyc;
        exp_q.push_back(e);
        we_pulses = 0;
        target = resp_cnt + 1;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wd;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (resp_cnt >= target) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            chk("response_timeout", 32'(resp_cnt), 32'(target));
            exp_q.delete();
        end
        @(negedge clk);
        chk("cache_we_pulses", 32'(we_pulses), 32'(exp_pulses));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tag_a[i]  = 4'h0;
            data_a[i] = 8'h00;
        end
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00; inv = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cache_we", 32'(cache_we), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_cache_addr", 32'(cache_addr), 32'd0);
        reset_n = 1'b1;

        // Cold read: miss, 2 waits, latency 4+2
        do_req(1'b0, 8'h35, 8'h00, 1'b0, 2, 8'hA7, 8'hA7, 6, 1'b1, 1);
        chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("cold_hit_cnt", 32'(hit_cnt), 32'd0);

        // Repeat read: hit in 2 cycles, no memory traffic
        do_req(1'b0, 8'h35, 8'h00, 1'b0, 0, 8'h00, 8'hA7, 2, 1'b0, 0);
        chk("repeat_hit_cnt", 32'(hit_cnt), 32'd1);

        // Conflict on index 5, then the original line misses again
        do_req(1'b0, 8'h45, 8'h00, 1'b0, 1, 8'h3B, 8'h3B, 5, 1'b1, 1);
        chk("conflict_miss_cnt", 32'(miss_cnt), 32'd2);
        do_req(1'b0, 8'h35, 8'h00, 1'b0, 0, 8'hA7, 8'hA7, 4, 1'b1, 1);
        chk("conflict2_miss_cnt", 32'(miss_cnt), 32'd3);

        // Write-through: cpu_rdata keeps the previous read value
        do_req(1'b1, 8'h12, 8'h5C, 1'b0, 0, 8'h00, 8'hA7, 3, 1'b1, 1);
        chk("write_hit_cnt", 32'(hit_cnt), 32'd1);
        chk("write_miss_cnt", 32'(miss_cnt), 32'd3);
        chk("write_array_data", 32'(data_a[2]), 32'h5C);
        do_req(1'b0, 8'h12, 8'h00, 1'b0, 0, 8'h00, 8'h5C, 2, 1'b0, 0);
        chk("write_then_hit_cnt", 32'(hit_cnt), 32'd2);

        // Invalidate wins over cpu_req; pending read then misses despite tag match
        do_req(1'b0, 8'h12, 8'h00, 1'b1, 1, 8'h99, 8'h99, 5, 1'b1, 1);
        chk("inv_miss_cnt", 32'(miss_cnt), 32'd4);
        chk("inv_hit_cnt", 32'(hit_cnt), 32'd2);

        // Reset while waiting in MEM_RD
        @(negedge clk);
        mem_wait_cfg = 1000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h77;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_mem_req_held", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("mid_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        repeat (3) @(negedge clk);
        mem_q.delete();
        reset_n = 1'b1;

        // After reset all lines are invalid; then saturate the hit counter
        do_req(1'b0, 8'h35, 8'h00, 1'b0, 0, 8'h11, 8'h11, 4, 1'b1, 1);
        chk("post_rst_miss_cnt", 32'(miss_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            do_req(1'b0, 8'h35, 8'h00, 1'b0, 0, 8'h00, 8'h11, 2, 1'b0, 0);
        end
        chk("sat_hit_cnt", 32'(hit_cnt), 32'hFF);
        chk("sat_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("mem_queue_empty", 32'(mem_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
